sw_loop_nest: RTL and testbench
===============================

Name: sw_loop_nest

Overview:
- Parametrised successor to the single-loop software-model block: a two-level nested counting loop modelled as a one-hot program counter (PC) plus data registers.
- Used as a crafted safety-property benchmark: the `prop` output must hold in every reachable state for the default parameters.
- Generalised over counter width, loop constants and outer-loop count. Adds reset, stall, a terminating DONE location and observable status outputs.

Parameters:
- W, 8, width of inner counter X
- KINIT, 0, value loaded into X at loop entry
- KINC, 3, X increment per inner iteration
- KCOND, 17, inner-loop continue bound (continue while X < KCOND)
- KPROP, 19, safety bound (error if X >= KPROP when checked)
- NOUTER, 4, number of outer iterations (>= 1)
- YW, 3, width of outer counter Y (must satisfy 2^YW > NOUTER)

Ports:
- clk, input, 1, clock; all state updates on the rising edge
- rst, input, 1, asynchronous active-high reset
- en, input, 1, step enable; when low all state holds
- pc, output, 8, one-hot PC: bit0 L0, bit1 L1, bit2 L2, bit3 L3, bit4 L4, bit5 L5, bit6 DONE, bit7 ERR
- x, output, W, inner counter X
- y, output, YW, outer counter Y
- done, output, 1, equals pc[6]
- err, output, 1, equals pc[7]
- onehot_ok, output, 1, registered one-hot check of pc
- prop, output, 1, !err && onehot_ok

Behaviour:
- Reset (async, rst=1): pc=8'b0000_0001 (L0), x=0, y=0, onehot_ok=1. Hence done=0, err=0, prop=1. Reset mid-run aborts immediately; no state is retained.
- Every rising edge with rst=0: onehot_ok <= (pc has exactly one bit set). This register is updated regardless of `en`.
- A step occurs on an edge where en=1 and onehot_ok=1. Otherwise pc, x and y all hold.
- Transitions per step; all compares are unsigned W-bit:
  - L0: x <= KINIT, y <= 0, go L1
  - L1: if x < KPROP go L2, else go ERR
  - L2: x <= x + KINC (mod 2^W, wrap permitted), go L3
  - L3: if x < KCOND go L1, else go L4
  - L4: if x < KPROP go L5, else go ERR
  - L5: if y + 1 < NOUTER then y <= y + 1, x <= KINIT, go L1; else y <= y + 1, go DONE
  - DONE and ERR: absorbing; pc, x and y hold forever until reset
- Decisions in each location use the pre-edge value of x.
- Each step is exactly 1 cycle; there is no pipelining.
- Outputs are direct register views, so they change on the same edge as the transition.
- With defaults: X sequence 0,3,…,18. Each outer iteration takes 20 steps (6×3 + 2). DONE is reached after 1 + 20·NOUTER = 81 steps. ERR is unreachable.
- `en` toggling never changes the trajectory, only its timing.

Decomposition:
- Package sw_loop_pkg:
  - localparams for the PC bit indices (L0..L5, DONE, ERR) and PC width 8
  - a typedef for the 8-bit PC vector
- Sub-module sw_loop_onehot_chk: parameter N; combinational N-bit exactly-one-hot detector.
- The top registers the detector output into onehot_ok.

Test Plan:
1. Defaults, en=1 after reset:
   - done rises after exactly 81 edges, with x=18, y=4.
   - prop=1 every cycle and err never asserts.
   - pc stays one-hot and visits L1 six times per outer pass.
2. KPROP=18, NOUTER=4:
   - err asserts after 20 steps, with pc=ERR and x=18.
   - prop falls on that edge and pc/x/y then hold for 50 further cycles.
3. W=4, KINIT=0, KINC=7, KCOND=15, KPROP=15, NOUTER=1:
   - x visits 7,14,5,12,3,10,1,8,15 (wrap).
   - err asserts after 29 steps.
4. Defaults with en randomly low about 50% of cycles:
   - identical pc/x/y trajectory to scenario 1, sampled per step.
   - done after exactly 81 en-high edges.
5. Assert rst for 1 cycle mid-run, at step 37 of the default run:
   - outputs return asynchronously (before the next edge) to pc=L0, x=0, y=0, prop=1.
   - a full 81-step run to DONE then repeats.
6. NOUTER=1, defaults otherwise:
   - done after 21 steps with y=1.
   - with en held high afterward, done stays high and x stays 18.

Source files
------------

// File: rtl/sw_loop_pkg.sv
// Shared definitions for the nested-loop software model: PC bit positions,
// the PC vector type and the one-hot location encoding.
package sw_loop_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned PC_L0   = 0;
    localparam int unsigned PC_L1   = 1;
    localparam int unsigned PC_L2   = 2;
    localparam int unsigned PC_L3   = 3;
    localparam int unsigned PC_L4   = 4;
    localparam int unsigned PC_L5   = 5;
    localparam int unsigned PC_DONE = 6;
    localparam int unsigned PC_ERR  = 7;

    typedef logic [PC_W-1:0] pc_t;

    // Program locations; each value sets only the bit at its PC index
    typedef enum logic [PC_W-1:0] {
        LOC_L0   = 8'b0000_0001,
        LOC_L1   = 8'b0000_0010,
        LOC_L2   = 8'b0000_0100,
        LOC_L3   = 8'b0000_1000,
        LOC_L4   = 8'b0001_0000,
        LOC_L5   = 8'b0010_0000,
        LOC_DONE = 8'b0100_0000,
        LOC_ERR  = 8'b1000_0000
    } loc_e;

endpackage

// File: rtl/sw_loop_onehot_chk.sv
// Combinational exactly-one-hot detector for an N-bit vector.
module sw_loop_onehot_chk #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] vec_i,
    output logic         onehot_o
);

    logic seen_one;
    logic seen_multi;

    // A second set bit after the first one marks the vector as not one-hot
    always_comb begin
        seen_one   = 1'b0;
        seen_multi = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (vec_i[i]) begin
                seen_multi = seen_multi | seen_one;
                seen_one   = 1'b1;
            end
        end
        onehot_o = seen_one & ~seen_multi;
    end

endmodule

// File: rtl/sw_loop_nest.sv
// Two-level nested counting loop modelled as a one-hot program counter with
// inner counter x and outer counter y; prop is the safety property output.
module sw_loop_nest
    import sw_loop_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned KINIT  = 0,
    parameter int unsigned KINC   = 3,
    parameter int unsigned KCOND  = 17,
    parameter int unsigned KPROP  = 19,
    parameter int unsigned NOUTER = 4,
    parameter int unsigned YW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output pc_t           pc,
    output logic [W-1:0]  x,
    output logic [YW-1:0] y,
    output logic          done,
    output logic          err,
    output logic          onehot_ok,
    output logic          prop
);

    localparam logic [W-1:0]  KINIT_X  = W'(KINIT);
    localparam logic [W-1:0]  KINC_X   = W'(KINC);
    localparam logic [W-1:0]  KCOND_X  = W'(KCOND);
    localparam logic [W-1:0]  KPROP_X  = W'(KPROP);
    localparam logic [YW:0]   NOUTER_Y = (YW+1)'(NOUTER);

    loc_e          pc_q, pc_d;
    logic [W-1:0]  x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          ok_q;
    logic          onehot_c;
    logic [YW:0]   y_inc;
    pc_t           pc_vec;

    sw_loop_onehot_chk #(
        .N (PC_W)
    ) u_onehot_chk (
        .vec_i    (pc_vec),
        .onehot_o (onehot_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= LOC_L0;
            x_q  <= '0;
            y_q  <= '0;
            ok_q <= 1'b1;
        end else begin
            pc_q <= pc_d;
            x_q  <= x_d;
            y_q  <= y_d;
            ok_q <= onehot_c;
        end
    end

    // One program step per enabled edge; a corrupted PC freezes execution
    always_comb begin
        pc_d  = pc_q;
        x_d   = x_q;
        y_d   = y_q;
        y_inc = {1'b0, y_q} + (YW+1)'(1);
        if (en && ok_q) begin
            case (pc_q)
                LOC_L0: begin
                    x_d  = KINIT_X;
                    y_d  = '0;
                    pc_d = LOC_L1;
                end
                LOC_L1: pc_d = (x_q < KPROP_X) ? LOC_L2 : LOC_ERR;
                LOC_L2: begin
                    x_d  = x_q + KINC_X;
                    pc_d = LOC_L3;
                end
                LOC_L3: pc_d = (x_q < KCOND_X) ? LOC_L1 : LOC_L4;
                LOC_L4: pc_d = (x_q < KPROP_X) ? LOC_L5 : LOC_ERR;
                LOC_L5: begin
                    y_d = y_inc[YW-1:0];
                    if (y_inc < NOUTER_Y) begin
                        x_d  = KINIT_X;
                        pc_d = LOC_L1;
                    end else begin
                        pc_d = LOC_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_vec    = pc_q;
    assign pc        = pc_vec;
    assign x         = x_q;
    assign y         = y_q;
    assign done      = pc_vec[PC_DONE];
    assign err       = pc_vec[PC_ERR];
    assign onehot_ok = ok_q;
    assign prop      = ~pc_vec[PC_ERR] & ok_q;

endmodule

// File: tb/tb_sw_loop_nest.sv
// Scoreboard bench for sw_loop_nest: four parameterisations share clk/rst/en;
// expected states come from running the nested loop as plain software.
module tb_sw_loop_nest;

    localparam int ND = 4;

    typedef struct packed {
        int pc;
        int x;
        int y;
    } st_t;

    // Per-instance parameters: defaults, KPROP=18, 4-bit wrap, NOUTER=1
    int p_w     [ND] = '{8, 8, 4, 8};
    int p_kinit [ND] = '{0, 0, 0, 0};
    int p_kinc  [ND] = '{3, 3, 7, 3};
    int p_kcond [ND] = '{17, 17, 15, 17};
    int p_kprop [ND] = '{19, 18, 15, 19};
    int p_nouter[ND] = '{4, 4, 1, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [7:0] pc0, pc1, pc2, pc3;
    logic [7:0] x0, x1, x3;
    logic [3:0] x2;
    logic [2:0] y0, y1, y2, y3;
    logic done0, done1, done2, done3;
    logic err0, err1, err2, err3;
    logic ok0, ok1, ok2, ok3;
    logic prop0, prop1, prop2, prop3;

    logic [7:0] pc_s [ND];
    int         x_s  [ND];
    int         y_s  [ND];
    logic       pr_s [ND];
    logic       ok_s [ND];
    logic       dn_s [ND];
    logic       er_s [ND];

    st_t tr [ND][$];
    st_t sb [ND][$];
    int  kidx [ND];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    sw_loop_nest u_d0 (
        .clk(clk), .rst(rst), .en(en), .pc(pc0), .x(x0), .y(y0),
        .done(done0), .err(err0), .onehot_ok(ok0), .prop(prop0)
    );
    sw_loop_nest #(.KPROP(18)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .pc(pc1), .x(x1), .y(y1),
        .done(done1), .err(err1), .onehot_ok(ok1), .prop(prop1)
    );
    sw_loop_nest #(.W(4), .KINIT(0), .KINC(7), .KCOND(15), .KPROP(15), .NOUTER(1)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .pc(pc2), .x(x2), .y(y2),
        .done(done2), .err(err2), .onehot_ok(ok2), .prop(prop2)
    );
    sw_loop_nest #(.NOUTER(1)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .pc(pc3), .x(x3), .y(y3),
        .done(done3), .err(err3), .onehot_ok(ok3), .prop(prop3)
    );

    always_comb begin
        pc_s[0] = pc0; x_s[0] = int'(x0); y_s[0] = int'(y0);
        pc_s[1] = pc1; x_s[1] = int'(x1); y_s[1] = int'(y1);
        pc_s[2] = pc2; x_s[2] = int'(x2); y_s[2] = int'(y2);
        pc_s[3] = pc3; x_s[3] = int'(x3); y_s[3] = int'(y3);
        pr_s[0] = prop0; pr_s[1] = prop1; pr_s[2] = prop2; pr_s[3] = prop3;
        ok_s[0] = ok0;   ok_s[1] = ok1;   ok_s[2] = ok2;   ok_s[3] = ok3;
        dn_s[0] = done0; dn_s[1] = done1; dn_s[2] = done2; dn_s[3] = done3;
        er_s[0] = err0;  er_s[1] = err1;  er_s[2] = err2;  er_s[3] = err3;
    end

    function automatic st_t mk(input int p, input int xv, input int yv);
        st_t s;
        s.pc = p;
        s.x  = xv;
        s.y  = yv;
        return s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Location indices: 1..5 loop body, 6 done, 7 error; state after each step
    task automatic gen_trace(input int d);
        int xv, yv, mask;
        mask = (1 << p_w[d]) - 1;
        tr[d].delete();
        xv = p_kinit[d] & mask;
        yv = 0;
        tr[d].push_back(mk(1, xv, yv));
        for (int guard = 0; guard < 2000; guard++) begin
            if (xv >= p_kprop[d]) begin tr[d].push_back(mk(7, xv, yv)); break; end
            tr[d].push_back(mk(2, xv, yv));
            xv = (xv + p_kinc[d]) & mask;
            tr[d].push_back(mk(3, xv, yv));
            if (xv < p_kcond[d]) begin tr[d].push_back(mk(1, xv, yv)); continue; end
            tr[d].push_back(mk(4, xv, yv));
            if (xv >= p_kprop[d]) begin tr[d].push_back(mk(7, xv, yv)); break; end
            tr[d].push_back(mk(5, xv, yv));
            yv = yv + 1;
            if (yv < p_nouter[d]) begin
                xv = p_kinit[d] & mask;
                tr[d].push_back(mk(1, xv, yv));
            end else begin
                tr[d].push_back(mk(6, xv, yv));
                break;
            end
        end
    endtask

    // Drive en for the next edge; an enabled edge queues the next trace state
    task automatic drive(input bit e);
        int i;
        @(negedge clk);
        en = e;
        if (e) begin
            for (int d = 0; d < ND; d++) begin
                i = (kidx[d] < tr[d].size()) ? kidx[d] : tr[d].size() - 1;
                sb[d].push_back(tr[d][i]);
                kidx[d]++;
            end
        end
    endtask

    task automatic clear_sb();
        for (int d = 0; d < ND; d++) begin
            sb[d].delete();
            kidx[d] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        clear_sb();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every edge, advance expectation on an enabled step and compare
    initial begin : monitor
        st_t cur [ND];
        bit  stepped, rst_seen;
        for (int d = 0; d < ND; d++) cur[d] = mk(0, 0, 0);
        forever begin
            @(posedge clk);
            stepped  = en && !rst;
            rst_seen = rst;
            #1;
            for (int d = 0; d < ND; d++) begin
                if (rst_seen) begin
                    cur[d] = mk(0, 0, 0);
                end else if (stepped) begin
                    if (sb[d].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty d%0d actual=step required=queued_state", d);
                    end else begin
                        cur[d] = sb[d].pop_front();
                    end
                end
                chk($sformatf("pc d%0d t%0t", d, $time), int'(pc_s[d]), 1 << cur[d].pc);
                chk($sformatf("x d%0d t%0t", d, $time), x_s[d], cur[d].x);
                chk($sformatf("y d%0d t%0t", d, $time), y_s[d], cur[d].y);
                chk($sformatf("prop d%0d t%0t", d, $time), int'(pr_s[d]), (cur[d].pc != 7) ? 1 : 0);
                chk($sformatf("onehot_ok d%0d t%0t", d, $time), int'(ok_s[d]), 1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        bit e;
        for (int d = 0; d < ND; d++) gen_trace(d);
        clear_sb();
        do_reset();

        // Free-running enabled run on all four instances
        for (int c = 0; c < 100; c++) drive(1'b1);
        @(negedge clk);
        en = 1'b0;
        chk("s1 done", int'(dn_s[0]), 1);
        chk("s1 x", x_s[0], 18);
        chk("s1 y", y_s[0], 4);
        chk("s2 err", int'(er_s[1]), 1);
        chk("s2 x", x_s[1], 18);
        chk("s2 prop", int'(pr_s[1]), 0);
        chk("s3 err", int'(er_s[2]), 1);
        chk("s3 x", x_s[2], 15);
        chk("s6 done", int'(dn_s[3]), 1);
        chk("s6 y", y_s[3], 1);
        chk("s6 x", x_s[3], 18);

        // Random stalls: trajectory must track en-high edges only
        do_reset();
        n = 0;
        while (n < 100) begin
            e = 1'($urandom_range(0, 1));
            drive(e);
            if (e) n++;
        end
        @(negedge clk);
        en = 1'b0;
        chk("s4 done", int'(dn_s[0]), 1);

        // Asynchronous reset in the middle of the default run
        do_reset();
        for (int c = 0; c < 37; c++) drive(1'b1);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        #1;
        chk("s5 async pc", int'(pc_s[0]), 1);
        chk("s5 async x", x_s[0], 0);
        chk("s5 async y", y_s[0], 0);
        chk("s5 async prop", int'(pr_s[0]), 1);
        clear_sb();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 90; c++) drive(1'b1);
        @(negedge clk);
        en = 1'b0;
        chk("s5 rerun done", int'(dn_s[0]), 1);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
